mips_perf_cnt_bank: RTL and testbench

//  Parametrised performance-counter bank for the multicycle MIPS core; replaces the fixed

---
 rtl/mips_perf_pkg.sv | 38 +++
 rtl/mips_perf_cnt_slice.sv | 122 ++++++++++++
 rtl/mips_perf_cnt_bank.sv | 108 ++++++++++
 tb/tb_mips_perf_cnt_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_perf_pkg.sv
// Shared definitions for the MIPS performance-counter bank.
// Contents: core event indices, register offsets within a counter window,
// CTRL/GLOBAL bit positions and the per-counter slice state encoding.
package mips_perf_pkg;

  // Event inputs driven by the core; indices above EVT_BR_TAKEN are user-defined.
  localparam int unsigned EVT_CYCLE    = 0;
  localparam int unsigned EVT_INST     = 1;
  localparam int unsigned EVT_BR       = 2;
  localparam int unsigned EVT_LD       = 3;
  localparam int unsigned EVT_ST       = 4;
  localparam int unsigned EVT_BR_TAKEN = 5;

  // Register offsets (cfg_addr[1:0]).
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_VALUE  = 2'd1;
  localparam logic [1:0] REG_SHADOW = 2'd2;
  localparam logic [1:0] REG_GLOBAL = 2'd3;

  // CTRL register fields.
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_SAT     = 1;
  localparam int unsigned CTRL_OVF_IE  = 2;
  localparam int unsigned CTRL_OVF     = 3;
  localparam int unsigned CTRL_SEL_LSB = 8;

  // GLOBAL register fields.
  localparam int unsigned GLB_FREEZE   = 0;
  localparam int unsigned GLB_SNAPSHOT = 1;
  localparam int unsigned GLB_OVF_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HELD = 2'd2
  } slice_state_e;

endpackage

// File: rtl/mips_perf_cnt_slice.sv
// One performance counter: live value, CTRL fields, overflow flag, optional
// shadow copy and a small run-state tracker.
// Ports: clk/rst (sync, active-low); wr_ctrl/wr_value strobes with wdata;
// evt_hit (selected event this cycle); freeze/snapshot from GLOBAL;
// evt_sel, ctrl_word, value, shadow, ovf, ovf_ie back to the bank.
// Macro PERF_CNT_SNAPSHOT_EN: when defined the shadow register exists,
// otherwise shadow reads as zero.
module mips_perf_cnt_slice
  import mips_perf_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned EVT_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_ctrl,
  input  logic                 wr_value,
  input  logic [31:0]          wdata,
  input  logic                 evt_hit,
  input  logic                 freeze,
  input  logic                 snapshot,
  output logic [EVT_SEL_W-1:0] evt_sel,
  output logic [31:0]          ctrl_word,
  output logic [CNT_W-1:0]     value,
  output logic [CNT_W-1:0]     shadow,
  output logic                 ovf,
  output logic                 ovf_ie
);

  logic             en_q, sat_q;
  logic             en_d, sat_d;
  logic             inc, ovf_hit, ovf_d, stuck_d;
  logic [CNT_W-1:0] value_d;
  slice_state_e     state;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  // Next counter value: a software write beats a same-cycle increment.
  always_comb begin
    inc     = en_q & ~freeze & evt_hit;
    value_d = value;
    ovf_hit = 1'b0;
    if (wr_value) begin
      value_d = wdata[CNT_W-1:0];
    end else if (inc) begin
      if (&value) begin
        ovf_hit = 1'b1;
        if (!sat_q) value_d = '0;
      end else begin
        value_d = value + CNT_W'(1);
      end
    end
    // A new overflow wins over a same-cycle W1C.
    ovf_d = ovf;
    if (ovf_hit) ovf_d = 1'b1;
    else if (wr_ctrl && wdata[CTRL_OVF]) ovf_d = 1'b0;
    en_d    = wr_ctrl ? wdata[CTRL_EN]  : en_q;
    sat_d   = wr_ctrl ? wdata[CTRL_SAT] : sat_q;
    stuck_d = sat_d & (&value_d);
  end

  // Counter state, CTRL fields and run-state tracker.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value   <= '0;
      ovf     <= 1'b0;
      en_q    <= 1'b0;
      sat_q   <= 1'b0;
      ovf_ie  <= 1'b0;
      evt_sel <= '0;
      state   <= ST_IDLE;
    end else begin
      value <= value_d;
      ovf   <= ovf_d;
      en_q  <= en_d;
      sat_q <= sat_d;
      if (wr_ctrl) begin
        ovf_ie  <= wdata[CTRL_OVF_IE];
        evt_sel <= wdata[CTRL_SEL_LSB +: EVT_SEL_W];
      end
      case (state)
        ST_IDLE: if (en_d) state <= (freeze || stuck_d) ? ST_HELD : ST_RUN;
        ST_RUN: begin
          if (!en_d) state <= ST_IDLE;
          else if (freeze || stuck_d) state <= ST_HELD;
        end
        ST_HELD: begin
          if (!en_d) state <= ST_IDLE;
          else if (!freeze && !stuck_d) state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_word                               = '0;
    ctrl_word[CTRL_EN]                      = en_q;
    ctrl_word[CTRL_SAT]                     = sat_q;
    ctrl_word[CTRL_OVF_IE]                  = ovf_ie;
    ctrl_word[CTRL_OVF]                     = ovf;
    ctrl_word[CTRL_SEL_LSB +: EVT_SEL_W]    = evt_sel;
  end

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q;

  // Snapshot captures the pre-increment value.
  always_ff @(posedge clk) begin
    if (!rst) shadow_q <= '0;
    else if (snapshot) shadow_q <= value;
  end

  assign shadow = shadow_q;
`else
  logic unused_snapshot;
  assign unused_snapshot = snapshot;
  assign shadow          = '0;
`endif

endmodule

// File: rtl/mips_perf_cnt_bank.sv
// Performance-counter bank for the multicycle MIPS core.
// Ports: clk, rst (sync, active-low); evt event pulses; cfg_wen/cfg_ren/
// cfg_addr/cfg_wdata register port; cfg_rdata/cfg_rvalid one-cycle read
// response; ovf_irq = registered OR of enabled overflow flags.
// Address = {counter index, reg[1:0]}: CTRL, VALUE, SHADOW, GLOBAL (idx 0).
// Macro PERF_CNT_SNAPSHOT_EN enables shadow registers and GLOBAL snapshot.
module mips_perf_cnt_bank
  import mips_perf_pkg::*;
#(
  parameter int unsigned NUM_CNT   = 8,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned NUM_EVT   = 16,
  parameter int unsigned EVT_SEL_W = $clog2(NUM_EVT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_EVT-1:0]         evt,
  input  logic                       cfg_wen,
  input  logic                       cfg_ren,
  input  logic [$clog2(NUM_CNT)+1:0] cfg_addr,
  input  logic [31:0]                cfg_wdata,
  output logic [31:0]                cfg_rdata,
  output logic                       cfg_rvalid,
  output logic                       ovf_irq
);

  localparam int unsigned IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  logic [1:0]           reg_sel;
  logic [IDX_W-1:0]     idx;
  logic                 idx_ok, glb_wr, snapshot, freeze;
  logic [31:0]          evt_ext, glb_word, rd_mux;
  logic [NUM_CNT-1:0]   ovf_vec, ie_vec;
  logic [EVT_SEL_W-1:0] sel_arr    [NUM_CNT];
  logic [31:0]          ctrl_arr   [NUM_CNT];
  logic [CNT_W-1:0]     value_arr  [NUM_CNT];
  logic [CNT_W-1:0]     shadow_arr [NUM_CNT];

  assign reg_sel  = cfg_addr[1:0];
  assign idx      = IDX_W'(cfg_addr >> 2);
  assign idx_ok   = 32'(idx) < NUM_CNT;
  assign glb_wr   = cfg_wen && (idx == '0) && (reg_sel == REG_GLOBAL);
  assign snapshot = glb_wr && cfg_wdata[GLB_SNAPSHOT];
  assign evt_ext  = 32'(evt);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_slice
    logic wr_c, wr_v, hit;
    assign wr_c = cfg_wen && idx_ok && (idx == IDX_W'(i)) && (reg_sel == REG_CTRL);
    assign wr_v = cfg_wen && idx_ok && (idx == IDX_W'(i)) && (reg_sel == REG_VALUE);
    // Selects beyond the implemented events never count.
    assign hit  = (32'(sel_arr[i]) < NUM_EVT) && evt_ext[5'(sel_arr[i])];

    mips_perf_cnt_slice #(
      .CNT_W     (CNT_W),
      .EVT_SEL_W (EVT_SEL_W)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (wr_c),
      .wr_value  (wr_v),
      .wdata     (cfg_wdata),
      .evt_hit   (hit),
      .freeze    (freeze),
      .snapshot  (snapshot),
      .evt_sel   (sel_arr[i]),
      .ctrl_word (ctrl_arr[i]),
      .value     (value_arr[i]),
      .shadow    (shadow_arr[i]),
      .ovf       (ovf_vec[i]),
      .ovf_ie    (ie_vec[i])
    );
  end

  always_comb begin
    glb_word                            = '0;
    glb_word[GLB_FREEZE]                = freeze;
    glb_word[GLB_OVF_LSB +: NUM_CNT]    = ovf_vec;
  end

  // Read mux over current register state (pre-write values).
  always_comb begin
    rd_mux = '0;
    if (idx_ok) begin
      case (reg_sel)
        REG_CTRL:   rd_mux = ctrl_arr[idx];
        REG_VALUE:  rd_mux = 32'(value_arr[idx]);
        REG_SHADOW: rd_mux = 32'(shadow_arr[idx]);
        default:    rd_mux = (idx == '0) ? glb_word : '0;
      endcase
    end
  end

  // Freeze, read response and interrupt registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      freeze     <= 1'b0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
      ovf_irq    <= 1'b0;
    end else begin
      if (glb_wr) freeze <= cfg_wdata[GLB_FREEZE];
      cfg_rvalid <= cfg_ren;
      if (cfg_ren) cfg_rdata <= rd_mux;
      ovf_irq <= |(ovf_vec & ie_vec);
    end
  end

endmodule

// File: tb/tb_mips_perf_cnt_bank.sv
// Directed bench for mips_perf_cnt_bank with 8 counters of 8 bits, 16 events.
module tb_mips_perf_cnt_bank;
  import mips_perf_pkg::*;

  localparam int unsigned NC = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned NE = 16;
  localparam int unsigned AW = 5;

  localparam int R_CTRL = 0, R_VALUE = 1, R_SHADOW = 2, R_GLOBAL = 3;

`ifdef PERF_CNT_SNAPSHOT_EN
  localparam logic [31:0] EXP_SH6 = 32'h7;
  localparam logic [31:0] EXP_SH5 = 32'h22;
`else
  localparam logic [31:0] EXP_SH6 = 32'h0;
  localparam logic [31:0] EXP_SH5 = 32'h0;
`endif

  logic          clk;
  logic          rst;
  logic [NE-1:0] evt;
  logic          cfg_wen, cfg_ren;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata, cfg_rdata;
  logic          cfg_rvalid, ovf_irq;

  int checks   = 0;
  int failures = 0;

  typedef enum int {OP_WR, OP_RD, OP_EV} op_e;
  typedef struct {
    op_e         op;
    int          idx;
    int          rg;
    logic [31:0] data;
    int          ncyc;
    string       name;
  } vec_t;
  vec_t tbl[$];

  mips_perf_cnt_bank #(
    .NUM_CNT (NC),
    .CNT_W   (CW),
    .NUM_EVT (NE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evt        (evt),
    .cfg_wen    (cfg_wen),
    .cfg_ren    (cfg_ren),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .ovf_irq    (ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int idx, input int rg);
    return AW'((idx << 2) | rg);
  endfunction

  task automatic wr(input int idx, input int rg, input logic [31:0] d);
    @(negedge clk);
    cfg_wen   = 1'b1;
    cfg_addr  = addr_of(idx, rg);
    cfg_wdata = d;
    @(negedge clk);
    cfg_wen   = 1'b0;
  endtask

  task automatic rd_check(input string name, input int idx, input int rg, input logic [31:0] exp);
    @(negedge clk);
    cfg_ren  = 1'b1;
    cfg_addr = addr_of(idx, rg);
    @(negedge clk);
    cfg_ren  = 1'b0;
    check({name, "_rvalid"}, 32'(cfg_rvalid), 32'h1);
    check(name, cfg_rdata, exp);
  endtask

  task automatic pulse_evt(input logic [NE-1:0] m, input int n);
    repeat (n) begin
      @(negedge clk);
      evt = m;
    end
    @(negedge clk);
    evt = '0;
  endtask

  function automatic void add(input op_e op, input int idx, input int rg,
                              input logic [31:0] d, input int n, input string nm);
    vec_t v;
    v.op = op; v.idx = idx; v.rg = rg; v.data = d; v.ncyc = n; v.name = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b0; evt = '1;
    cfg_wen = 1'b0; cfg_ren = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    // Reset held three cycles with every event high.
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(cfg_rvalid), 32'h0);
    check("rst_irq", 32'(ovf_irq), 32'h0);
    rst = 1'b1;
    evt = '0;

    // Reset state
    add(OP_RD, 0, R_CTRL,   32'h0, 0, "rst_ctrl0");
    add(OP_RD, 0, R_VALUE,  32'h0, 0, "rst_val0");
    add(OP_RD, 7, R_VALUE,  32'h0, 0, "rst_val7");
    add(OP_RD, 7, R_SHADOW, 32'h0, 0, "rst_sh7");
    add(OP_RD, 0, R_GLOBAL, 32'h0, 0, "rst_glb");
    // Counting: cnt0 on EVT_INST, cnt1 on EVT_CYCLE
    add(OP_WR, 0, R_CTRL, 32'h1 | (32'(EVT_INST) << 8), 0, "");
    add(OP_WR, 1, R_CTRL, 32'h1 | (32'(EVT_CYCLE) << 8), 0, "");
    for (int k = 0; k < 5; k++) begin
      add(OP_EV, 0, 0, 32'h3, 1, "");
      add(OP_EV, 0, 0, 32'h1, 1, "");
    end
    add(OP_EV, 0, 0, 32'h1, 2, "");
    add(OP_RD, 0, R_CTRL,  32'h101, 0, "cnt0_ctrl");
    add(OP_RD, 0, R_VALUE, 32'd5,   0, "cnt0_inst");
    add(OP_RD, 1, R_VALUE, 32'd12,  0, "cnt1_cycle");
    add(OP_WR, 0, R_CTRL, 32'h0, 0, "");
    add(OP_WR, 1, R_CTRL, 32'h0, 0, "");
    // Wrap mode on cnt2
    add(OP_WR, 2, R_CTRL,  32'h201, 0, "");
    add(OP_WR, 2, R_VALUE, 32'hFE,  0, "");
    add(OP_EV, 0, 0, 32'h4, 3, "");
    add(OP_RD, 2, R_VALUE,  32'h01,     0, "wrap_val");
    add(OP_RD, 2, R_CTRL,   32'h209,    0, "wrap_ctrl");
    add(OP_RD, 0, R_GLOBAL, 32'h4_0000, 0, "wrap_glb");
    add(OP_RD, 2, R_GLOBAL, 32'h0,      0, "glb_idx2");
    // Saturate mode on cnt3
    add(OP_WR, 3, R_CTRL,  32'h303, 0, "");
    add(OP_WR, 3, R_VALUE, 32'hFE,  0, "");
    add(OP_EV, 0, 0, 32'h8, 3, "");
    add(OP_RD, 3, R_VALUE,  32'hFF,     0, "sat_val");
    add(OP_RD, 3, R_CTRL,   32'h30B,    0, "sat_ctrl");
    add(OP_RD, 0, R_GLOBAL, 32'hC_0000, 0, "sat_glb");
    // VALUE write truncates to counter width
    add(OP_WR, 4, R_VALUE, 32'h1234, 0, "");
    add(OP_RD, 4, R_VALUE, 32'h34, 0, "trunc_val");
    // Freeze on cnt5
    add(OP_WR, 5, R_CTRL,   32'h501, 0, "");
    add(OP_WR, 5, R_VALUE,  32'h20,  0, "");
    add(OP_WR, 0, R_GLOBAL, 32'h1,   0, "");
    add(OP_EV, 0, 0, 32'h20, 10, "");
    add(OP_RD, 5, R_VALUE,  32'h20,     0, "frz_val");
    add(OP_RD, 0, R_GLOBAL, 32'hC_0001, 0, "frz_glb");
    add(OP_WR, 0, R_GLOBAL, 32'h0, 0, "");
    add(OP_EV, 0, 0, 32'h20, 2, "");
    add(OP_RD, 5, R_VALUE, 32'h22, 0, "unfrz_val");

    foreach (tbl[k]) begin
      case (tbl[k].op)
        OP_WR:   wr(tbl[k].idx, tbl[k].rg, tbl[k].data);
        OP_RD:   rd_check(tbl[k].name, tbl[k].idx, tbl[k].rg, tbl[k].data);
        default: pulse_evt(tbl[k].data[NE-1:0], tbl[k].ncyc);
      endcase
    end

    // Interrupt enable: irq follows one cycle after ovf_ie is set.
    check("irq_off", 32'(ovf_irq), 32'h0);
    wr(3, R_CTRL, 32'h307);
    check("irq_lag", 32'(ovf_irq), 32'h0);
    @(negedge clk);
    check("irq_on", 32'(ovf_irq), 32'h1);
    // W1C clears ovf, irq drops one cycle later.
    wr(3, R_CTRL, 32'h30F);
    check("w1c_lag", 32'(ovf_irq), 32'h1);
    @(negedge clk);
    check("w1c_irq", 32'(ovf_irq), 32'h0);
    rd_check("w1c_ctrl", 3, R_CTRL, 32'h307);
    // W1C in the same cycle as a new saturating overflow keeps ovf set.
    @(negedge clk);
    evt = 16'h8; cfg_wen = 1'b1; cfg_addr = addr_of(3, R_CTRL); cfg_wdata = 32'h30F;
    @(negedge clk);
    evt = '0; cfg_wen = 1'b0;
    rd_check("w1c_race_ctrl", 3, R_CTRL, 32'h30F);
    rd_check("w1c_race_val", 3, R_VALUE, 32'hFF);
    wr(3, R_CTRL, 32'h8);
    wr(2, R_CTRL, 32'h8);
    rd_check("clr_glb", 0, R_GLOBAL, 32'h0);
    check("clr_irq", 32'(ovf_irq), 32'h0);

    // VALUE write in an event cycle wins.
    wr(4, R_CTRL, 32'h401);
    @(negedge clk);
    evt = 16'h10; cfg_wen = 1'b1; cfg_addr = addr_of(4, R_VALUE); cfg_wdata = 32'h10;
    @(negedge clk);
    evt = '0; cfg_wen = 1'b0;
    rd_check("wr_vs_inc", 4, R_VALUE, 32'h10);
    // Read and write together return the old value.
    @(negedge clk);
    cfg_ren = 1'b1; cfg_wen = 1'b1; cfg_addr = addr_of(4, R_VALUE); cfg_wdata = 32'h55;
    @(negedge clk);
    cfg_ren = 1'b0; cfg_wen = 1'b0;
    check("rw_rvalid", 32'(cfg_rvalid), 32'h1);
    check("rw_old", cfg_rdata, 32'h10);
    rd_check("rw_new", 4, R_VALUE, 32'h55);
    wr(4, R_CTRL, 32'h0);

    // Snapshot in an event cycle, then three more events.
    wr(6, R_CTRL,  32'h601);
    wr(6, R_VALUE, 32'h7);
    @(negedge clk);
    evt = 16'h40; cfg_wen = 1'b1; cfg_addr = addr_of(0, R_GLOBAL); cfg_wdata = 32'h2;
    @(negedge clk);
    cfg_wen = 1'b0;
    repeat (3) @(negedge clk);
    evt = '0;
    rd_check("snap_val6", 6, R_VALUE,  32'h0B);
    rd_check("snap_sh6",  6, R_SHADOW, EXP_SH6);
    rd_check("snap_sh5",  5, R_SHADOW, EXP_SH5);
    rd_check("snap_glb",  0, R_GLOBAL, 32'h0);

    // Back-to-back reads.
    @(negedge clk);
    cfg_ren = 1'b1; cfg_addr = addr_of(6, R_VALUE);
    @(negedge clk);
    cfg_addr = addr_of(5, R_VALUE);
    check("b2b_rvalid0", 32'(cfg_rvalid), 32'h1);
    check("b2b_data0", cfg_rdata, 32'h0B);
    @(negedge clk);
    cfg_ren = 1'b0;
    check("b2b_rvalid1", 32'(cfg_rvalid), 32'h1);
    check("b2b_data1", cfg_rdata, 32'h22);
    @(negedge clk);
    check("b2b_idle", 32'(cfg_rvalid), 32'h0);

    // Reset arriving with a pending read drops the response.
    @(negedge clk);
    cfg_ren = 1'b1; cfg_addr = addr_of(6, R_VALUE); rst = 1'b0;
    @(negedge clk);
    cfg_ren = 1'b0;
    check("rstrd_rvalid", 32'(cfg_rvalid), 32'h0);
    check("rstrd_rdata", cfg_rdata, 32'h0);
    @(negedge clk);
    check("rstrd_rvalid2", 32'(cfg_rvalid), 32'h0);
    rst = 1'b1;
    rd_check("rst2_val6",  6, R_VALUE, 32'h0);
    rd_check("rst2_ctrl5", 5, R_CTRL,  32'h0);
    check("rst2_irq", 32'(ovf_irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
